// File: rtl/vedic_pkg.sv
// vedic_pkg: shared FSM state type and pipeline constants for the Vedic MAC
package vedic_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int PROD_W    = 16;
    localparam int DRAIN_CYC = 2;
endpackage

// File: rtl/vedic_8X8.sv
// vedic_8X8: combinational 8x8 unsigned multiplier built from Urdhva-Tiryagbhyam partial products
module vedic_8X8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] t, u;
        t = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
        u = {1'b0, x[1] & y[1]} + {1'b0, t[1]};
        return {u, t[0], x[0] & y[0]};
    endfunction
    function automatic logic [7:0] v4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] ll, hl, lh, hh;
        ll = v2(x[1:0], y[1:0]);
        hl = v2(x[3:2], y[1:0]);
        lh = v2(x[1:0], y[3:2]);
        hh = v2(x[3:2], y[3:2]);
        return {4'b0, ll} + {2'b0, hl, 2'b0} + {2'b0, lh, 2'b0} + {hh, 4'b0};
    endfunction
    logic [7:0] ll, hl, lh, hh;
    always_comb begin
        ll = v4(a[3:0], b[3:0]);
        hl = v4(a[7:4], b[3:0]);
        lh = v4(a[3:0], b[7:4]);
        hh = v4(a[7:4], b[7:4]);
        p  = {8'b0, ll} + {4'b0, hl, 4'b0} + {4'b0, lh, 4'b0} + {hh, 8'b0};
    end
endmodule

// File: rtl/vedic_mac_8x8.sv
// vedic_mac_8x8: framed multiply-accumulate around a registered vedic_8X8 with result handshake
module vedic_mac_8x8
    import vedic_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);
    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          dcnt_q, dcnt_d;
    logic [7:0]          a_q, a_d, b_q, b_d;
    logic                s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [PROD_W-1:0]   prod_q, prod_d, prod_w;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [ACC_W:0]      sum;
    logic                beat;

    vedic_8X8 u_mul (.a(a_q), .b(b_q), .p(prod_w));

    assign in_ready  = state_q == RUN;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign beat      = in_ready && in_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        a_d     = beat ? a : a_q;
        b_d     = beat ? b : b_q;
        s1_v_d  = beat;
        s2_v_d  = s1_v_q;
        prod_d  = prod_w;
        sum     = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
        acc_d   = s2_v_q ? sum[ACC_W-1:0] : acc_q;
        ovf_d   = ovf_q | (s2_v_q & sum[ACC_W]);
        case (state_q)
            IDLE: if (start) begin
                acc_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = len;
                state_d = len != '0 ? RUN : DONE;
            end
            RUN: if (beat) begin
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DRAIN;
                    dcnt_d  = 2'(DRAIN_CYC - 1);
                end
            end
            // leaves on the edge that folds the final product into the accumulator
            DRAIN: begin
                dcnt_d  = dcnt_q - 2'd1;
                state_d = dcnt_q == 2'd0 ? DONE : DRAIN;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            prod_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s1_v_q  <= s1_v_d;
            s2_v_q  <= s2_v_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
